// File: rtl/mem_store_buffer_pkg.sv
// Shared widths and cpu read/write encodings for the store buffer slice.
package mem_store_buffer_pkg;

  localparam int unsigned CPU_AW = 64;
  localparam int unsigned CPU_DW = 64;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/sbuf_fwd_match.sv
// Youngest-match search over the pending store entries for read forwarding.
module sbuf_fwd_match
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = CPU_AW,
  parameter int unsigned DW    = CPU_DW,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0]    addrs [DEPTH],
  input  logic [DW-1:0]    datas [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [AW-1:0]    address,
  output logic             hit,
  output logic [DW-1:0]    data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (addrs[idx] == address)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Write-posting FIFO between the cpu memory port and RAM, with read forwarding.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = CPU_AW,
  parameter int unsigned DW    = CPU_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] cpu_address,
  input  logic          cpu_rw,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wvalid,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_wready,
  output logic          buf_empty,
  output logic          buf_full,
  output logic          overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    offset;
  logic             enq;
  logic             deq;
  logic             accept;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  assign buf_empty  = (count == '0);
  assign buf_full   = (count == CW'(DEPTH));
  assign mem_wvalid = ~buf_empty;
  assign mem_waddr  = addr_mem[head];
  assign mem_wdata  = data_mem[head];
  assign mem_raddr  = cpu_address;

  assign enq = (cpu_rw == RW_WRITE);
  assign deq = mem_wvalid & mem_wready;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign accept = enq & (~buf_full | deq);

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        addr_mem[tail] <= cpu_address;
        data_mem[tail] <= cpu_wdata;
        tail           <= tail + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      if (accept && !deq) begin
        count <= count + CW'(1);
      end else if (!accept && deq) begin
        count <= count - CW'(1);
      end
      if (enq && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    valid  = '0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset   = PW'(i) - head;
      valid[i] = ({1'b0, offset} < count);
    end
  end

  sbuf_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fwd (
    .addrs  (addr_mem),
    .datas  (data_mem),
    .valid  (valid),
    .head   (head),
    .address(cpu_address),
    .hit    (fwd_hit),
    .data   (fwd_data)
  );

  assign cpu_rdata = ((cpu_rw == RW_READ) && fwd_hit) ? fwd_data : mem_rdata;

endmodule
